instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Read-side initiator for the combinational instruction ROM. Owns the PC,
//  drives the 64-bit byte address, and captures the returned 32-bit word into
//  an IF/ID register with a valid/ready handshake toward decode.
//  Accepts branch redirects and traps illegal fetch addresses.
// PARAMETERS
//  MEM_SIZE  1024  instruction memory size in bytes; power of two, > 4
//  RESET_PC  0     PC value loaded on reset; word-aligned
// PORTS
//  clk             in   1   single clock; all state updates on posedge
//  reset_n         in   1   asynchronous, active-low reset
//  imem_addr       out  64  byte address to instruction ROM
//  imem_instr      in   32  instruction word returned combinationally
//  redirect_valid  in   1   load redirect_pc into PC this cycle
//  redirect_pc     in   64  branch/jump target, byte address
//  dec_valid       out  1   IF/ID entry valid
//  dec_ready       in   1   decode accepts the entry this cycle
//  dec_instr       out  32  fetched instruction
//  dec_pc          out  64  address of dec_instr
//  fault           out  1   sticky illegal-fetch flag
//  fault_pc        out  64  offending address
//  halted          out  1   branch-to-self halt seen (FETCH_HALT_DETECT_EN only)
// BEHAVIOUR
//  - Reset (async, immediate, also mid-operation): pc=RESET_PC, state=RUN,
//    dec_valid=0, dec_instr=0, dec_pc=0, fault=0, fault_pc=0, halted=0.
//  - imem_addr = pc, combinationally, in every state.
//  - States: RUN, FAULT, HALT.
//  - RUN, no redirect, slot free (!dec_valid | dec_ready), pc legal:
//      dec_instr<=imem_instr, dec_pc<=pc, dec_valid<=1, pc<=pc+4.
//      Latency is 1 clk from address to dec_*.
//  - RUN, slot busy (dec_valid & !dec_ready): pc and all dec_* hold.
//      dec_* must stay stable until accepted.
//  - RUN, slot free, no new fetch possible: dec_valid<=0.
//  - Legal pc: pc[1:0]==0 and pc+3 < MEM_SIZE.
//    An illegal pc in RUN on a fetch cycle -> FAULT:
//      fault<=1, fault_pc<=pc, dec_valid<=0.
//    The current entry is dropped even if unaccepted.
//  - redirect_valid in RUN has priority over fetch and stall:
//      pc<=redirect_pc, dec_valid<=0 (squash), no capture this cycle.
//    Redirect + dec_ready same cycle: squash wins; decode sees no transfer.
//    An illegal redirect_pc faults on the next cycle's fetch check.
//  - FAULT and HALT are terminal until reset_n:
//      redirects ignored, dec_valid=0, pc frozen.
//  - PC arithmetic is 64-bit unsigned with no wrap handling.
//    Running past MEM_SIZE faults at pc==MEM_SIZE.
// CONFIGURATION
//  FETCH_HALT_DETECT_EN defined:
//    - Accepting an entry (dec_valid & dec_ready) with dec_instr==32'h14000000
//      (B #0) moves the block to HALT and sets halted<=1.
//    - No further entries are issued.
//  FETCH_HALT_DETECT_EN undefined:
//    - halted is tied to 0.
//    - B #0 is fetched like any other word; the HALT state does not exist.
// TESTING
//  1. ROM words 0..3 = A,B,C,D; dec_ready=1; release reset ->
//     dec_valid rises 1 clk later; dec_pc 0,4,8,C and dec_instr A,B,C,D
//     on consecutive clks.
//  2. dec_ready=0 for 3 clks while dec_pc=4 ->
//     dec_pc/dec_instr/imem_addr stable.
//     After release: next dec_pc=8, no word dropped or duplicated.
//  3. redirect_valid with redirect_pc=0x40 while dec_valid=1, dec_ready=0 ->
//     dec_valid=0 next clk, then dec_pc=0x40.
//  4. redirect_pc=0x42 ->
//     fault=1, fault_pc=0x42, dec_valid stays 0.
//     Later redirect to 0x0 is ignored; reset_n low clears fault.
//  5. Sequential run to 0x3FC with MEM_SIZE=1024 ->
//     0x3FC issued, then fault=1, fault_pc=0x400.
//  6. FETCH_HALT_DETECT_EN, word at 0x10 = 32'h14000000 ->
//     halted=1 after accept; no dec_valid afterwards;
//     reset_n pulse mid-halt restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and IF/ID register for a combinational instruction ROM.
// Drives the byte address, captures the returned word into a valid/ready slot toward
// decode, honours branch redirects and stops on an illegal fetch address.
// Optional feature: define FETCH_HALT_DETECT_EN to stop fetching once decode accepts
// a branch-to-self (B #0, 32'h14000000); otherwise halted is tied low.
module instruction_fetch #(
   parameter int unsigned MEM_SIZE = 1024,
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_instr,
   output logic [63:0] dec_pc,
   output logic        fault,
   output logic [63:0] fault_pc,
   output logic        halted
);

   // Highest byte address at which a full 32-bit word still fits in the ROM
   localparam logic [63:0] LAST_PC = 64'(MEM_SIZE) - 64'd4;
`ifdef FETCH_HALT_DETECT_EN
   localparam logic [31:0] HALT_WORD = 32'h1400_0000;
`endif

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FAULT = 2'd1
`ifdef FETCH_HALT_DETECT_EN
      , ST_HALT = 2'd2
`endif
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [63:0] r_pc;
   logic        r_dec_valid;
   logic [31:0] r_dec_instr;
   logic [63:0] r_dec_pc;
   logic        r_fault;
   logic [63:0] r_fault_pc;

   logic [63:0] w_pc_next;
   logic        w_dec_valid_next;
   logic [31:0] w_dec_instr_next;
   logic [63:0] w_dec_pc_next;
   logic        w_fault_next;
   logic [63:0] w_fault_pc_next;

   logic        w_slot_free;
   logic        w_pc_legal;

   // Slot can take a new word when it is empty or being drained this cycle
   assign w_slot_free = !r_dec_valid || dec_ready;
   // Word-aligned and the whole word lies inside the ROM
   assign w_pc_legal  = (r_pc[1:0] == 2'b00) && (r_pc <= LAST_PC);

`ifdef FETCH_HALT_DETECT_EN
   logic r_halted;
   logic w_halted_next;
   logic w_halt_hit;
   // Decode is taking a branch-to-self: nothing after it can ever execute
   assign w_halt_hit = r_dec_valid && dec_ready && (r_dec_instr == HALT_WORD);
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state: redirect keeps us running, then halt detection, then fetch legality
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN: begin
            if (redirect_valid) begin
               w_state_next = ST_RUN;
            end
`ifdef FETCH_HALT_DETECT_EN
            else if (w_halt_hit) begin
               w_state_next = ST_HALT;
            end
`endif
            else if (w_slot_free && !w_pc_legal) begin
               w_state_next = ST_FAULT;
            end
         end
         default: w_state_next = r_state;
      endcase
   end

   // Output/datapath next values; terminal states only keep the slot empty
   always_comb begin
      w_pc_next        = r_pc;
      w_dec_valid_next = r_dec_valid;
      w_dec_instr_next = r_dec_instr;
      w_dec_pc_next    = r_dec_pc;
      w_fault_next     = r_fault;
      w_fault_pc_next  = r_fault_pc;
`ifdef FETCH_HALT_DETECT_EN
      w_halted_next    = r_halted;
`endif
      case (r_state)
         ST_RUN: begin
            if (redirect_valid) begin
               // Squash wins over any same-cycle accept or fetch
               w_pc_next        = redirect_pc;
               w_dec_valid_next = 1'b0;
            end
`ifdef FETCH_HALT_DETECT_EN
            else if (w_halt_hit) begin
               w_dec_valid_next = 1'b0;
               w_halted_next    = 1'b1;
            end
`endif
            else if (w_slot_free) begin
               if (w_pc_legal) begin
                  w_dec_instr_next = imem_instr;
                  w_dec_pc_next    = r_pc;
                  w_dec_valid_next = 1'b1;
                  w_pc_next        = r_pc + 64'd4;
               end else begin
                  w_fault_next     = 1'b1;
                  w_fault_pc_next  = r_pc;
                  w_dec_valid_next = 1'b0;
               end
            end
         end
         default: w_dec_valid_next = 1'b0;
      endcase
   end

   // PC, IF/ID slot and fault/halt flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc        <= RESET_PC;
         r_dec_valid <= 1'b0;
         r_dec_instr <= 32'd0;
         r_dec_pc    <= 64'd0;
         r_fault     <= 1'b0;
         r_fault_pc  <= 64'd0;
`ifdef FETCH_HALT_DETECT_EN
         r_halted    <= 1'b0;
`endif
      end else begin
         r_pc        <= w_pc_next;
         r_dec_valid <= w_dec_valid_next;
         r_dec_instr <= w_dec_instr_next;
         r_dec_pc    <= w_dec_pc_next;
         r_fault     <= w_fault_next;
         r_fault_pc  <= w_fault_pc_next;
`ifdef FETCH_HALT_DETECT_EN
         r_halted    <= w_halted_next;
`endif
      end
   end

   assign imem_addr = r_pc;
   assign dec_valid = r_dec_valid;
   assign dec_instr = r_dec_instr;
   assign dec_pc    = r_dec_pc;
   assign fault     = r_fault;
   assign fault_pc  = r_fault_pc;
`ifdef FETCH_HALT_DETECT_EN
   assign halted    = r_halted;
`else
   assign halted    = 1'b0;
`endif

endmodule
